mc_control: RTL

- Multi-cycle sequencer for the existing register-file/ALU/dmem datapath.
- Fetches an instruction over a req/ready handshake, decodes opcode/funct, then drives the datapath control lines (regDst, aluSrc, alu0..5, memWr, wSrc, regWr, memSign, loadHigh, link, dataSize) over EXEC/MEM/WB cycles.
- Owns PC-write sequencing.
- Stalls on slow memory, times out hung transfers, and stops on halt or illegal instructions.

---
 rtl/ctrl_pkg.sv | 73 +++++++
 rtl/mc_decode.sv | 75 +++++++
 rtl/mc_control.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/ctrl_pkg.sv
// Shared types and encodings for the multi-cycle control sequencer.
package ctrl_pkg;

    localparam int unsigned OPW  = 6;
    localparam int unsigned ALUW = 6;
    localparam int unsigned PCSW = 2;
    localparam int unsigned DSW  = 2;

    typedef enum logic [2:0] {
        ST_FETCH, ST_DECODE, ST_EXEC, ST_MEM, ST_WB, ST_HALT, ST_ERROR
    } state_e;

    typedef enum logic [2:0] {
        IC_ALU, IC_LOAD, IC_STORE, IC_BEQ, IC_BNE, IC_J, IC_JR, IC_JAL
    } iclass_e;

    localparam logic [OPW-1:0] OP_RTYPE = 6'h00;
    localparam logic [OPW-1:0] OP_J     = 6'h02;
    localparam logic [OPW-1:0] OP_JAL   = 6'h03;
    localparam logic [OPW-1:0] OP_BEQ   = 6'h04;
    localparam logic [OPW-1:0] OP_BNE   = 6'h05;
    localparam logic [OPW-1:0] OP_ADDI  = 6'h08;
    localparam logic [OPW-1:0] OP_LUI   = 6'h0F;
    localparam logic [OPW-1:0] OP_LB    = 6'h20;
    localparam logic [OPW-1:0] OP_LH    = 6'h21;
    localparam logic [OPW-1:0] OP_LW    = 6'h23;
    localparam logic [OPW-1:0] OP_LBU   = 6'h24;
    localparam logic [OPW-1:0] OP_LHU   = 6'h25;
    localparam logic [OPW-1:0] OP_SB    = 6'h28;
    localparam logic [OPW-1:0] OP_SH    = 6'h29;
    localparam logic [OPW-1:0] OP_SW    = 6'h2B;
    localparam logic [OPW-1:0] OP_HALT  = 6'h3F;

    localparam logic [OPW-1:0] FN_SLL = 6'h00;
    localparam logic [OPW-1:0] FN_SRL = 6'h02;
    localparam logic [OPW-1:0] FN_JR  = 6'h08;
    localparam logic [OPW-1:0] FN_ADD = 6'h20;
    localparam logic [OPW-1:0] FN_SUB = 6'h22;
    localparam logic [OPW-1:0] FN_AND = 6'h24;
    localparam logic [OPW-1:0] FN_OR  = 6'h25;
    localparam logic [OPW-1:0] FN_SLT = 6'h2A;

    // Shift codes are the only ones with bit2 set and bit5 clear.
    localparam logic [ALUW-1:0] ALU_ADD = 6'h00;
    localparam logic [ALUW-1:0] ALU_SUB = 6'h01;
    localparam logic [ALUW-1:0] ALU_AND = 6'h02;
    localparam logic [ALUW-1:0] ALU_OR  = 6'h03;
    localparam logic [ALUW-1:0] ALU_SLL = 6'h04;
    localparam logic [ALUW-1:0] ALU_SRL = 6'h06;
    localparam logic [ALUW-1:0] ALU_SLT = 6'h21;

    localparam logic [PCSW-1:0] PC_SEL_INC    = 2'b00;
    localparam logic [PCSW-1:0] PC_SEL_BRANCH = 2'b01;
    localparam logic [PCSW-1:0] PC_SEL_JUMP   = 2'b10;
    localparam logic [PCSW-1:0] PC_SEL_REG    = 2'b11;

    localparam logic [DSW-1:0] DSIZE_WORD = 2'b11;
    localparam logic [DSW-1:0] DSIZE_HALF = 2'b01;
    localparam logic [DSW-1:0] DSIZE_BYTE = 2'b00;

    typedef struct packed {
        iclass_e         iclass;
        logic            regDst;
        logic            aluSrc;
        logic            wSrc;
        logic            memSign;
        logic            loadHigh;
        logic            link;
        logic [ALUW-1:0] aluCtl;
        logic [DSW-1:0]  dataSize;
    } ctrl_t;

endpackage

// File: rtl/mc_decode.sv
// Combinational opcode/funct decode into the datapath control bundle.
module mc_decode
    import ctrl_pkg::*;
(
    input  logic [OPW-1:0] opcode,
    input  logic [OPW-1:0] funct,
    output ctrl_t          ctl,
    output logic           isHalt,
    output logic           isIllegal
);

    always_comb begin
        ctl        = '0;
        ctl.iclass = IC_ALU;
        isHalt     = 1'b0;
        isIllegal  = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                ctl.regDst = 1'b1;
                case (funct)
                    FN_ADD:  ctl.aluCtl = ALU_ADD;
                    FN_SUB:  ctl.aluCtl = ALU_SUB;
                    FN_AND:  ctl.aluCtl = ALU_AND;
                    FN_OR:   ctl.aluCtl = ALU_OR;
                    FN_SLT:  ctl.aluCtl = ALU_SLT;
                    FN_SLL:  ctl.aluCtl = ALU_SLL;
                    FN_SRL:  ctl.aluCtl = ALU_SRL;
                    FN_JR: begin
                        ctl.regDst = 1'b0;
                        ctl.iclass = IC_JR;
                    end
                    default: isIllegal = 1'b1;
                endcase
            end
            OP_ADDI: ctl.aluSrc = 1'b1;
            OP_LUI: begin
                ctl.aluSrc   = 1'b1;
                ctl.loadHigh = 1'b1;
            end
            OP_LW, OP_LH, OP_LHU, OP_LB, OP_LBU: begin
                ctl.iclass  = IC_LOAD;
                ctl.aluSrc  = 1'b1;
                ctl.wSrc    = 1'b1;
                ctl.memSign = (opcode == OP_LH) || (opcode == OP_LB);
                ctl.dataSize = (opcode == OP_LW) ? DSIZE_WORD :
                               ((opcode == OP_LH) || (opcode == OP_LHU)) ? DSIZE_HALF : DSIZE_BYTE;
            end
            OP_SW, OP_SH, OP_SB: begin
                ctl.iclass   = IC_STORE;
                ctl.aluSrc   = 1'b1;
                ctl.dataSize = (opcode == OP_SW) ? DSIZE_WORD :
                               (opcode == OP_SH) ? DSIZE_HALF : DSIZE_BYTE;
            end
            OP_BEQ: begin
                ctl.iclass = IC_BEQ;
                ctl.aluCtl = ALU_SUB;
            end
            OP_BNE: begin
                ctl.iclass = IC_BNE;
                ctl.aluCtl = ALU_SUB;
            end
            OP_J: ctl.iclass = IC_J;
            // Link path: datapath routes pc+4 to r31 through the load-high mux.
            OP_JAL: begin
                ctl.iclass   = IC_JAL;
                ctl.link     = 1'b1;
                ctl.loadHigh = 1'b1;
                ctl.aluCtl   = ALU_ADD;
            end
            OP_HALT: isHalt = 1'b1;
            default: isIllegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/mc_control.sv
// Multi-cycle sequencer: fetch/decode/exec/mem/wb with bus timeout and sticky halt/error flags.
module mc_control
    import ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned TW      = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [OPW-1:0]   opcode,
    input  logic [OPW-1:0]   funct,
    input  logic             zFlag,
    input  logic             imem_ready,
    input  logic             dmem_ready,
    output logic             imem_req,
    output logic             dmem_req,
    output logic             ir_wr,
    output logic             pc_wr,
    output logic [PCSW-1:0]  pc_sel,
    output logic             regDst,
    output logic             aluSrc,
    output logic             memWr,
    output logic             wSrc,
    output logic             regWr,
    output logic             memSign,
    output logic             loadHigh,
    output logic             link,
    output logic [ALUW-1:0]  alu_ctl,
    output logic [DSW-1:0]   dataSize,
    output logic             halted,
    output logic             illegal,
    output logic             bus_err
);

    state_e          state, nextState;
    ctrl_t           ctlQ, decCtl;
    logic            decHalt, decIllegal;
    logic [TW-1:0]   waitCnt;
    logic            busErrQ, illegalQ;
    logic            timeoutHit, cntInc;

    logic            imemReqC, dmemReqC, irWrC, pcWrC, memWrC, regWrC, ctlActive;
    logic            setBusErr, setIllegal;
    logic [PCSW-1:0] pcSelC;

    mc_decode uDecode (
        .opcode    (opcode),
        .funct     (funct),
        .ctl       (decCtl),
        .isHalt    (decHalt),
        .isIllegal (decIllegal)
    );

    assign timeoutHit = (waitCnt == TW'(TIMEOUT));
    assign cntInc     = ((state == ST_FETCH) && !imem_ready) || ((state == ST_MEM) && !dmem_ready);

    // State, bundle, wait counter and sticky flags.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= ST_FETCH;
            ctlQ     <= '0;
            waitCnt  <= '0;
            busErrQ  <= 1'b0;
            illegalQ <= 1'b0;
        end else begin
            state <= nextState;
            if (state == ST_DECODE) ctlQ <= decCtl;
            if (nextState != state) waitCnt <= '0;
            else if (cntInc)        waitCnt <= waitCnt + TW'(1);
            if (setBusErr)  busErrQ  <= 1'b1;
            if (setIllegal) illegalQ <= 1'b1;
        end
    end

    // Next state and strobes; a ready in the timeout cycle still completes the transfer.
    always_comb begin
        nextState  = state;
        imemReqC   = 1'b0;
        dmemReqC   = 1'b0;
        irWrC      = 1'b0;
        pcWrC      = 1'b0;
        pcSelC     = PC_SEL_INC;
        memWrC     = 1'b0;
        regWrC     = 1'b0;
        ctlActive  = 1'b0;
        setBusErr  = 1'b0;
        setIllegal = 1'b0;
        case (state)
            ST_FETCH: begin
                imemReqC = 1'b1;
                if (imem_ready) begin
                    irWrC     = 1'b1;
                    pcWrC     = 1'b1;
                    nextState = ST_DECODE;
                end else if (timeoutHit) begin
                    setBusErr = 1'b1;
                    nextState = ST_ERROR;
                end
            end
            ST_DECODE: begin
                if (decHalt) nextState = ST_HALT;
                else if (decIllegal) begin
                    setIllegal = 1'b1;
                    nextState  = ST_ERROR;
                end else nextState = ST_EXEC;
            end
            ST_EXEC: begin
                ctlActive = 1'b1;
                nextState = ST_FETCH;
                case (ctlQ.iclass)
                    IC_BEQ: if (zFlag) begin
                        pcWrC  = 1'b1;
                        pcSelC = PC_SEL_BRANCH;
                    end
                    IC_BNE: if (!zFlag) begin
                        pcWrC  = 1'b1;
                        pcSelC = PC_SEL_BRANCH;
                    end
                    IC_J: begin
                        pcWrC  = 1'b1;
                        pcSelC = PC_SEL_JUMP;
                    end
                    IC_JR: begin
                        pcWrC  = 1'b1;
                        pcSelC = PC_SEL_REG;
                    end
                    IC_JAL: begin
                        pcWrC     = 1'b1;
                        pcSelC    = PC_SEL_JUMP;
                        nextState = ST_WB;
                    end
                    IC_LOAD, IC_STORE: nextState = ST_MEM;
                    default: nextState = ST_WB;
                endcase
            end
            ST_MEM: begin
                ctlActive = 1'b1;
                dmemReqC  = 1'b1;
                memWrC    = (ctlQ.iclass == IC_STORE);
                if (dmem_ready) begin
                    nextState = (ctlQ.iclass == IC_STORE) ? ST_FETCH : ST_WB;
                end else if (timeoutHit) begin
                    setBusErr = 1'b1;
                    nextState = ST_ERROR;
                end
            end
            ST_WB: begin
                ctlActive = 1'b1;
                regWrC    = 1'b1;
                nextState = ST_FETCH;
            end
            ST_HALT, ST_ERROR: nextState = state;
            default: nextState = ST_FETCH;
        endcase
    end

    // Every output is forced low while reset is held.
    always_comb begin
        imem_req = rst_n & imemReqC;
        dmem_req = rst_n & dmemReqC;
        ir_wr    = rst_n & irWrC;
        pc_wr    = rst_n & pcWrC;
        pc_sel   = rst_n ? pcSelC : '0;
        memWr    = rst_n & memWrC;
        regWr    = rst_n & regWrC;
        regDst   = rst_n & ctlActive & ctlQ.regDst;
        aluSrc   = rst_n & ctlActive & ctlQ.aluSrc;
        wSrc     = rst_n & ctlActive & ctlQ.wSrc;
        memSign  = rst_n & ctlActive & ctlQ.memSign;
        loadHigh = rst_n & ctlActive & ctlQ.loadHigh;
        link     = rst_n & ctlActive & ctlQ.link;
        alu_ctl  = (rst_n && ctlActive) ? ctlQ.aluCtl : '0;
        dataSize = (rst_n && ctlActive) ? ctlQ.dataSize : '0;
        halted   = rst_n && (state == ST_HALT);
        illegal  = rst_n & illegalQ;
        bus_err  = rst_n & busErrQ;
    end

endmodule
